// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per clock, start/busy/done handshake.
// Optional macro BIN2BCD_CHANGE_DETECT_EN: also start a conversion whenever bin differs from the last converted value.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic [0:0]            dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    function automatic longint pow10(input int n);
        longint r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    if (pow10(DIGITS) <= (longint'(1) << WIDTH) - 1) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    logic [0:0]          state;
    logic [WIDTH-1:0]    shreg;
    logic [4*DIGITS-1:0] scratch;
    logic [CW-1:0]       step;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] nxt_scratch;
    logic [WIDTH-1:0]    nxt_shreg;
    logic                trigger;
    logic                last_step;

    // Handshake: start is only looked at in IDLE; busy is high from the edge
    // after acceptance until the done edge; done is a one-cycle pulse coinciding
    // with the bcd update. Starts seen while busy are dropped, not queued.
`ifdef BIN2BCD_CHANGE_DETECT_EN
    logic [WIDTH-1:0] last_bin;
    assign trigger = start | (bin != last_bin);
`else
    assign trigger = start;
`endif

    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // The top bit of the top digit falls off; the DIGITS check keeps it zero.
    assign nxt_scratch = {adj[4*DIGITS-2:0], shreg[WIDTH-1]};
    assign nxt_shreg   = {shreg[WIDTH-2:0], 1'b0};
    assign last_step   = (step == CW'(WIDTH - 1));
    assign dbg_state   = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bcd     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            scratch <= '0;
            step    <= '0;
`ifdef BIN2BCD_CHANGE_DETECT_EN
            last_bin <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (trigger) begin
                    shreg   <= bin;
                    scratch <= '0;
                    step    <= '0;
                    busy    <= 1'b1;
                    state   <= SHIFT;
`ifdef BIN2BCD_CHANGE_DETECT_EN
                    last_bin <= bin;
`endif
                end
            end else begin
                scratch <= nxt_scratch;
                shreg   <= nxt_shreg;
                step    <= step + CW'(1);
                if (last_step) begin
                    bcd   <= nxt_scratch;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: arithmetic reference model checked every cycle, directed cases plus random traffic.
module tb_bin2bcd_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int BW     = 4 * DIGITS;
`ifdef BIN2BCD_CHANGE_DETECT_EN
    localparam bit CD = 1'b1;
`else
    localparam bit CD = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] bin = '0;
    logic [BW-1:0]    bcd;
    logic             busy;
    logic             done;
    logic [0:0]       dbg_state;

    int errors = 0;
    int checks = 0;

    bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .start(start), .bin(bin),
        .bcd(bcd), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [BW-1:0] to_bcd(input int v);
        logic [BW-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is a WIDTH-cycle delay of the decimal digits of bin.
    logic          model_valid = 1'b0;
    logic          m_busy, m_done;
    logic [BW-1:0] m_bcd, m_pending;
    int            m_left;
    logic [WIDTH-1:0] m_last;

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_bcd <= '0; m_pending <= '0;
            m_left <= 0; m_last <= '0; model_valid <= 1'b1;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1; m_bcd <= m_pending;
                end
                m_left <= m_left - 1;
            end else if (start || (CD && bin != m_last)) begin
                m_busy <= 1'b1; m_left <= WIDTH; m_pending <= to_bcd(int'(bin)); m_last <= bin;
            end
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            chk("bcd", 32'(bcd), 32'(m_bcd));
            chk("busy", 32'(busy), 32'(m_busy));
            chk("done", 32'(done), 32'(m_done));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (cycles < budget) begin
            tick();
            start = 1'b0;
            cycles++;
            if (done === 1'b1) return;
        end
        chk({name, "_timeout"}, 32'(0), 32'(1));
    endtask

    task automatic count_done(input int n, output int dcount);
        dcount = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (done === 1'b1) dcount++;
        end
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; start = 1'b0; bin = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    int cyc, dc;

    initial begin
        do_reset();
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);

        // 255: busy over the 8 step cycles, result after the 8th step
        bin = 8'hFF; start = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tick();
            start = 1'b0;
            chk("ff_busy", 32'(busy), 32'h1);
            chk("ff_nodone", 32'(done), 32'h0);
        end
        tick();
        chk("ff_done", 32'(done), 32'h1);
        chk("ff_bcd", 32'(bcd), 32'h255);
        chk("ff_busy_end", 32'(busy), 32'h0);

        // zero, single-cycle done
        tick();
        bin = 8'd0; start = 1'b1;
        wait_done("zero", 20, cyc);
        chk("zero_bcd", 32'(bcd), 32'h000);
        tick();
        chk("zero_pulse", 32'(done), 32'h0);

        // back-to-back 99 then 100
        bin = 8'd99; start = 1'b1;
        wait_done("b2b_a", 20, cyc);
        chk("b2b_a_bcd", 32'(bcd), 32'h099);
        bin = 8'd100; start = 1'b1;
        wait_done("b2b_b", 20, cyc);
        chk("b2b_gap", 32'(cyc), 32'(WIDTH + 1));
        chk("b2b_b_bcd", 32'(bcd), 32'h100);

        // start and bin change during conversion are ignored
        tick();
        bin = 8'd200; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        start = 1'b1; bin = 8'd7;
        tick(); start = 1'b0; bin = 8'd55;
        wait_done("ign", 20, cyc);
        chk("ign_bcd", 32'(bcd), 32'h200);
`ifndef BIN2BCD_CHANGE_DETECT_EN
        count_done(15, dc);
        chk("ign_no_extra_done", 32'(dc), 32'h0);
`endif

        // reset mid-conversion aborts
        do_reset();
        bin = 8'd255; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1; bin = 8'd0;
        tick(); rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_bcd", 32'(bcd), 32'h0);
        count_done(15, dc);
        chk("abort_no_done", 32'(dc), 32'h0);

`ifdef BIN2BCD_CHANGE_DETECT_EN
        do_reset();
        count_done(20, dc);
        chk("cd_idle_after_rst", 32'(dc), 32'h0);
        bin = 8'd1;
        count_done(20, dc);
        chk("cd_one_done", 32'(dc), 32'h1);
        chk("cd_bcd1", 32'(bcd), 32'h001);
        bin = 8'd2;
        count_done(20, dc);
        chk("cd_two_done", 32'(dc), 32'h1);
        chk("cd_bcd2", 32'(bcd), 32'h002);
        count_done(20, dc);
        chk("cd_hold", 32'(dc), 32'h0);
`endif

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            tick();
            bin   = WIDTH'($urandom);
            start = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 80) == 0);
        end
        tick();
        rst = 1'b0; start = 1'b0;
        repeat (WIDTH + 3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
